regfile_param: RTL and testbench
================================

# regfile_param

Parametrised successor of the team's 32x32 CPU register file. Generalises width and depth, and keeps register 0 hard-wired to zero as an option. Adds per-byte write strobes, write-to-read bypass and a background soft-clear sequencer with a Busy flag. Sits in the decode stage, feeding the ALU operand muxes; the clear sequencer serves context-switch and debug flush.

## Interface
- WIDTH, 32, data width in bits; must be a multiple of 8.
- DEPTH, 32, number of registers; must be a power of two, 2..256.
- ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes; 0 = register 0 is an ordinary register.
- AW, $clog2(DEPTH), address width (derived, not overridden).

Ports:
- Clock  in  1  sole clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high; sampled on the rising edge of Clock.
- ReadAddr1  in  AW  read port 1 address.
- ReadAddr2  in  AW  read port 2 address.
- ReadData1  out  WIDTH  read port 1 data (combinational).
- ReadData2  out  WIDTH  read port 2 data (combinational).
- RegWrite  in  1  write enable.
- WriteAddr  in  AW  write address.
- WriteData  in  WIDTH  write data.
- WriteStrobe  in  WIDTH/8  per-byte write enable; bit i covers WriteData[8i+7:8i].
- Clear  in  1  single-cycle request to start a soft clear.
- Busy  out  1  high while the soft clear is in progress.
- WriteDropped  out  1  registered pulse; the write of the previous cycle was discarded.

## Operation
- Storage: DEPTH x WIDTH flops. No RAM macro, because the block has two asynchronous read ports.
- Write, accepted when RegWrite=1, Busy=0 and not (ZERO_REG=1 and WriteAddr=0):
  - each byte whose WriteStrobe bit is 1 takes its byte of WriteData;
  - all other bytes keep their value.
  - WriteStrobe=0 is a legal no-op. It does not count as a dropped write.
- Read, per port independently:
  - if ZERO_REG=1 and the address is 0: output 0;
  - else if a write is accepted this cycle to the same address: output the merged word (strobed bytes from WriteData, other bytes from storage). This is write-first bypass.
  - else: output the stored word.
- Soft-clear state machine, two states, IDLE and CLEAR:
  - IDLE, Clear=1: go to CLEAR with ClrPtr set to (ZERO_REG ? 1 : 0).
  - CLEAR, each cycle: zero registers[ClrPtr]. If ClrPtr=DEPTH-1, go to IDLE; else increment ClrPtr.
  - Clear=1 while in CLEAR is ignored and does not restart the sequence.
  - Busy = (state == CLEAR).
- While Busy=1:
  - RegWrite=1 writes are discarded and the bypass is disabled.
  - Reads return current storage contents, so some registers may be cleared and others not yet.
- WriteDropped: set for one cycle after any cycle with RegWrite=1 and Busy=1. Writes to register 0 when ZERO_REG=1 do not set it.
- Reset=1 on a rising edge, taking priority over everything:
  - all registers go to 0;
  - state goes to IDLE, ClrPtr to 0;
  - WriteDropped goes to 0.
  - A write or Clear in the same cycle is ignored. This also holds mid-clear.

## Timing
- Read latency 0: ReadData is a combinational function of the addresses, storage and the current write inputs.
- Write latency 1: data is visible in storage after the edge, and visible the same cycle through the bypass.
- Clear duration: DEPTH-ZERO_REG cycles with Busy=1.
  - Busy rises on the edge where Clear=1 is sampled.
  - Busy falls on the edge that zeroes register DEPTH-1.
  - A write in the first cycle after Busy falls is accepted.
- Values after reset:
  - Busy=0, WriteDropped=0;
  - ReadData1/2 = 0 for all addresses (while no write is being bypassed).
- ClrPtr is AW bits wide. Termination compares against DEPTH-1, so the pointer never wraps.
- A write with WriteAddr equal to ClrPtr cannot collide with the clear, because writes are blocked during CLEAR.

## Test plan
- Reset, then write 0xDEADBEEF to r5 with strobe 0xF. Next cycle ReadAddr1=5 gives 0xDEADBEEF; ReadAddr2=0 gives 0.
- r5=0xDEADBEEF, write 0x11223344 to r5 with strobe 0b0101. In the same cycle ReadData1 (addr 5) = 0xDE22BE44 via bypass; the stored value is 0xDE22BE44 after the edge.
- ZERO_REG=1: write 0xFFFFFFFF to r0. ReadData=0 in that cycle and afterwards, and WriteDropped=0. With ZERO_REG=0 the same write reads back 0xFFFFFFFF.
- Fill r1..r31 with their indices, then pulse Clear:
  - Busy is high for exactly 31 cycles;
  - r1..r31 read 0 afterwards;
  - a write to r7 at Busy cycle 3 is discarded, with WriteDropped=1 on the next cycle.
- Mid-clear reset: pulse Clear, then assert Reset at Busy cycle 10. Next cycle Busy=0 and every register reads 0; a subsequent write is accepted.
- WIDTH=64, DEPTH=8: write 0x0123456789ABCDEF to r7 with strobe 0xFF and read it back on both ports. A clear lasts 7 cycles.

Source files
------------

// File: rtl/regfile_param.sv
// Parametrised register file: two combinational read ports with write-first
// bypass, byte-strobed writes, optional hard-wired zero register and a soft-clear sequencer.
module regfile_param #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [AW-1:0]    ReadAddr1,
  input  logic [AW-1:0]    ReadAddr2,
  output logic [WIDTH-1:0] ReadData1,
  output logic [WIDTH-1:0] ReadData2,
  input  logic             RegWrite,
  input  logic [AW-1:0]    WriteAddr,
  input  logic [WIDTH-1:0] WriteData,
  input  logic [WIDTH/8-1:0] WriteStrobe,
  input  logic             Clear,
  output logic             Busy,
  output logic             WriteDropped,
  output logic             dbg_state
);

  localparam int NB = WIDTH / 8;

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  logic [WIDTH-1:0] regs [DEPTH];
  state_t           state;
  logic [AW-1:0]    clr_ptr;
  logic             dropped_q;

  logic             busy;
  logic             zero_wr;
  logic             wr_ok;
  logic [WIDTH-1:0] wmask;
  logic [WIDTH-1:0] merged;

  assign busy    = (state == CLEAR);
  assign zero_wr = (ZERO_REG != 0) && (WriteAddr == '0);
  assign wr_ok   = RegWrite && !busy && !zero_wr;

  always_comb begin
    wmask = '0;
    for (int i = 0; i < NB; i++) wmask[8*i +: 8] = {8{WriteStrobe[i]}};
  end

  // Merged word is both the bypass value and the value committed at the edge.
  assign merged = (WriteData & wmask) | (regs[WriteAddr] & ~wmask);

  always_comb begin
    if ((ZERO_REG != 0) && (ReadAddr1 == '0))   ReadData1 = '0;
    else if (wr_ok && (ReadAddr1 == WriteAddr)) ReadData1 = merged;
    else                                        ReadData1 = regs[ReadAddr1];
  end

  always_comb begin
    if ((ZERO_REG != 0) && (ReadAddr2 == '0))   ReadData2 = '0;
    else if (wr_ok && (ReadAddr2 == WriteAddr)) ReadData2 = merged;
    else                                        ReadData2 = regs[ReadAddr2];
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      state     <= IDLE;
      clr_ptr   <= '0;
      dropped_q <= 1'b0;
    end else begin
      dropped_q <= RegWrite && busy && !zero_wr;
      case (state)
        IDLE: begin
          if (wr_ok) regs[WriteAddr] <= merged;
          if (Clear) begin
            state   <= CLEAR;
            clr_ptr <= AW'(ZERO_REG);
          end
        end
        CLEAR: begin
          regs[clr_ptr] <= '0;
          // Compare before incrementing so the pointer never wraps.
          if (clr_ptr == AW'(DEPTH - 1)) state <= IDLE;
          else                           clr_ptr <= clr_ptr + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign Busy         = busy;
  assign WriteDropped = dropped_q;
  assign dbg_state    = state;

endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: three configurations driven by shared stimulus and
// checked every cycle against a behavioural array model, plus literal checks.
module tb_regfile_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic [4:0]  ra1 = '0, ra2 = '0, wa = '0;
  logic [63:0] wd = '0;
  logic [7:0]  ws = '0;
  logic        regwrite = 1'b0, clear = 1'b0;

  int checks = 0;
  int failures = 0;
  bit started = 1'b0;

  // Configurations: 0 = 32x32 zero-reg, 1 = 32x32 plain, 2 = 64x8 zero-reg
  int w_c[3] = '{32, 32, 64};
  int d_c[3] = '{32, 32, 8};
  int z_c[3] = '{1, 0, 1};

  logic [31:0] d0_rd1, d0_rd2, d1_rd1, d1_rd2;
  logic [63:0] d2_rd1, d2_rd2;
  logic [2:0]  busy_a, drop_a, dbg_a;
  wire  [63:0] rd1_a [3];
  wire  [63:0] rd2_a [3];
  assign rd1_a[0] = {32'b0, d0_rd1};
  assign rd2_a[0] = {32'b0, d0_rd2};
  assign rd1_a[1] = {32'b0, d1_rd1};
  assign rd2_a[1] = {32'b0, d1_rd2};
  assign rd1_a[2] = d2_rd1;
  assign rd2_a[2] = d2_rd2;

  regfile_param #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1)) u_dut0 (
    .Clock(clk), .Reset(reset), .ReadAddr1(ra1), .ReadAddr2(ra2),
    .ReadData1(d0_rd1), .ReadData2(d0_rd2), .RegWrite(regwrite), .WriteAddr(wa),
    .WriteData(wd[31:0]), .WriteStrobe(ws[3:0]), .Clear(clear),
    .Busy(busy_a[0]), .WriteDropped(drop_a[0]), .dbg_state(dbg_a[0]));

  regfile_param #(.WIDTH(32), .DEPTH(32), .ZERO_REG(0)) u_dut1 (
    .Clock(clk), .Reset(reset), .ReadAddr1(ra1), .ReadAddr2(ra2),
    .ReadData1(d1_rd1), .ReadData2(d1_rd2), .RegWrite(regwrite), .WriteAddr(wa),
    .WriteData(wd[31:0]), .WriteStrobe(ws[3:0]), .Clear(clear),
    .Busy(busy_a[1]), .WriteDropped(drop_a[1]), .dbg_state(dbg_a[1]));

  regfile_param #(.WIDTH(64), .DEPTH(8), .ZERO_REG(1)) u_dut2 (
    .Clock(clk), .Reset(reset), .ReadAddr1(ra1[2:0]), .ReadAddr2(ra2[2:0]),
    .ReadData1(d2_rd1), .ReadData2(d2_rd2), .RegWrite(regwrite), .WriteAddr(wa[2:0]),
    .WriteData(wd), .WriteStrobe(ws), .Clear(clear),
    .Busy(busy_a[2]), .WriteDropped(drop_a[2]), .dbg_state(dbg_a[2]));

  // Behavioural model: storage array, remaining-clear count, dropped flag.
  logic [63:0] m_mem [3][32];
  int          m_rem [3];
  bit          m_drop [3];

  initial begin
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 32; i++) m_mem[k][i] = '0;
      m_rem[k] = 0;
      m_drop[k] = 1'b0;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [63:0] wmask_of(input int k);
    return (w_c[k] == 64) ? '1 : ((64'd1 << w_c[k]) - 64'd1);
  endfunction

  function automatic logic [63:0] merged_of(input int k);
    logic [63:0] old, res;
    int a;
    a = int'(wa) % d_c[k];
    old = m_mem[k][a];
    res = old;
    for (int b = 0; b < w_c[k] / 8; b++)
      if (ws[b]) res[8*b +: 8] = wd[8*b +: 8];
    return res & wmask_of(k);
  endfunction

  function automatic bit accept_of(input int k);
    int a;
    a = int'(wa) % d_c[k];
    return regwrite && (m_rem[k] == 0) && !(z_c[k] == 1 && a == 0);
  endfunction

  function automatic logic [63:0] exp_rd(input int k, input logic [4:0] addr);
    int a;
    a = int'(addr) % d_c[k];
    if (z_c[k] == 1 && a == 0) return '0;
    if (accept_of(k) && a == int'(wa) % d_c[k]) return merged_of(k);
    return m_mem[k][a];
  endfunction

  always @(negedge clk) begin
    if (started) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("rd1[%0d]", k), rd1_a[k], exp_rd(k, ra1));
        chk($sformatf("rd2[%0d]", k), rd2_a[k], exp_rd(k, ra2));
        chk($sformatf("busy[%0d]", k), 64'(busy_a[k]), 64'(m_rem[k] != 0));
        chk($sformatf("dbg[%0d]", k), 64'(dbg_a[k]), 64'(m_rem[k] != 0));
        chk($sformatf("drop[%0d]", k), 64'(drop_a[k]), 64'(m_drop[k]));
      end
    end
    // Advance the model to the state after the coming rising edge.
    for (int k = 0; k < 3; k++) begin
      if (reset) begin
        for (int i = 0; i < 32; i++) m_mem[k][i] = '0;
        m_rem[k] = 0;
        m_drop[k] = 1'b0;
      end else begin
        int a;
        bit busy_now;
        a = int'(wa) % d_c[k];
        busy_now = (m_rem[k] != 0);
        if (accept_of(k)) m_mem[k][a] = merged_of(k);
        m_drop[k] = regwrite && busy_now && !(z_c[k] == 1 && a == 0);
        if (busy_now) begin
          m_mem[k][d_c[k] - m_rem[k]] = '0;
          m_rem[k] = m_rem[k] - 1;
        end else if (clear) begin
          m_rem[k] = d_c[k] - z_c[k];
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [4:0] a, input logic [63:0] d, input logic [7:0] s);
    regwrite = 1'b1; wa = a; wd = d; ws = s;
  endtask

  int bc[3];

  initial begin
    reset = 1'b1;
    tick();
    started = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("reset_busy", 64'(busy_a[0]), 64'd0);
    chk("reset_rd1", rd1_a[0], 64'd0);

    // Full write then read back
    write(5'd5, 64'hDEADBEEF, 8'h0F);
    tick();
    regwrite = 1'b0; ra1 = 5'd5; ra2 = 5'd0;
    #1;
    chk("r5_full", rd1_a[0], 64'hDEADBEEF);
    chk("r0_zero", rd2_a[0], 64'h0);

    // Partial strobe with same-cycle bypass
    write(5'd5, 64'h11223344, 8'h05);
    #1;
    chk("r5_bypass", rd1_a[0], 64'hDE22BE44);
    tick();
    regwrite = 1'b0;
    #1;
    chk("r5_stored", rd1_a[0], 64'hDE22BE44);

    // Register 0 with and without the zero option
    write(5'd0, 64'hFFFFFFFF, 8'h0F);
    ra1 = 5'd0;
    #1;
    chk("r0_zr_bypass", rd1_a[0], 64'h0);
    chk("r0_plain_bypass", rd1_a[1], 64'hFFFFFFFF);
    tick();
    regwrite = 1'b0;
    #1;
    chk("r0_zr_after", rd1_a[0], 64'h0);
    chk("r0_zr_nodrop", 64'(drop_a[0]), 64'd0);
    chk("r0_plain_after", rd1_a[1], 64'hFFFFFFFF);

    // Fill r1..r31 with their indices
    for (int i = 1; i < 32; i++) begin
      write(5'(i), 64'(i), 8'h0F);
      tick();
    end
    regwrite = 1'b0;

    // Soft clear with a blocked write at Busy cycle 3
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int k = 0; k < 3; k++) bc[k] = 0;
    for (int c = 0; c < 40; c++) begin
      #1;
      for (int k = 0; k < 3; k++) if (busy_a[k]) bc[k]++;
      if (c == 3) chk("drop_after_blocked", 64'(drop_a[0]), 64'd1);
      if (c == 2) write(5'd7, 64'hA5A5A5A5, 8'h0F);
      else regwrite = 1'b0;
      tick();
    end
    chk("clear_len_32zr", 64'(bc[0]), 64'd31);
    chk("clear_len_32", 64'(bc[1]), 64'd32);
    chk("clear_len_64x8", 64'(bc[2]), 64'd7);
    for (int i = 0; i < 32; i++) begin
      ra1 = 5'(i); ra2 = 5'(31 - i);
      #1;
      chk($sformatf("cleared_r%0d", i), rd1_a[0], 64'h0);
    end

    // Reset in the middle of a clear
    write(5'd3, 64'h12345678, 8'h0F);
    tick();
    regwrite = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int c = 0; c < 9; c++) tick();
    chk("midclear_busy", 64'(busy_a[0]), 64'd1);
    reset = 1'b1;
    write(5'd4, 64'h55555555, 8'h0F);
    tick();
    reset = 1'b0; regwrite = 1'b0;
    #1;
    chk("midclear_reset_busy", 64'(busy_a[0]), 64'd0);
    for (int i = 0; i < 32; i++) begin
      ra1 = 5'(i);
      #1;
      chk($sformatf("after_reset_r%0d", i), rd1_a[0], 64'h0);
    end
    write(5'd9, 64'hCAFEF00D, 8'h0F);
    tick();
    regwrite = 1'b0; ra1 = 5'd9;
    #1;
    chk("post_reset_write", rd1_a[0], 64'hCAFEF00D);

    // Wide configuration
    write(5'd7, 64'h0123456789ABCDEF, 8'hFF);
    tick();
    regwrite = 1'b0; ra1 = 5'd7; ra2 = 5'd7;
    #1;
    chk("wide_rd1", rd1_a[2], 64'h0123456789ABCDEF);
    chk("wide_rd2", rd2_a[2], 64'h0123456789ABCDEF);

    // Randomised traffic against the model
    for (int n = 0; n < 3000; n++) begin
      ra1 = 5'($urandom_range(0, 31));
      ra2 = 5'($urandom_range(0, 31));
      wa = 5'($urandom_range(0, 31));
      wd = {$urandom, $urandom};
      ws = 8'($urandom_range(0, 255));
      regwrite = ($urandom_range(0, 3) != 0);
      clear = ($urandom_range(0, 39) == 0);
      reset = ($urandom_range(0, 299) == 0);
      tick();
    end
    reset = 1'b0; regwrite = 1'b0; clear = 1'b0;
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
